// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: idle/serve/play/miss/game-over flow, score, lives, speed, serve position.
// Latency: start_btn edge to SERVE 3 clk; hit/miss to score/lives 1 clk; frame_tick to state change 1 clk.
// Backpressure: none; pulse inputs are consumed on the clk they are sampled.
// Ports: clk, rst (async, active-high); frame_tick, start_btn, hit, miss in;
//        ball_run, ball_load, serve_x, serve_y, ball_speed, score (BCD), lives, flash, game_over out.
module pong_game_ctrl #(
  parameter int LIVES            = 3,
  parameter int SERVE_FRAMES     = 60,
  parameter int MISS_FRAMES      = 90,
  parameter int HITS_PER_SPEEDUP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       hit,
  input  logic       miss,
  output logic       ball_run,
  output logic       ball_load,
  output logic [9:0] serve_x,
  output logic [8:0] serve_y,
  output logic [1:0] ball_speed,
  output logic [7:0] score,
  output logic [2:0] lives,
  output logic       flash,
  output logic       game_over
);

  localparam int FC_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  // At least 4 bits so the flash bit (frame_cnt[3]) always exists.
  localparam int FCW    = ($clog2(FC_MAX) > 4) ? $clog2(FC_MAX) : 4;
  localparam int HCW    = $clog2(HITS_PER_SPEEDUP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [FCW-1:0]   frame_cnt, frame_cnt_n;
  logic [HCW-1:0]   hit_cnt, hit_cnt_n;
  logic [7:0]       lfsr;
  logic [7:0]       score_n;
  logic [2:0]       lives_n;
  logic [1:0]       speed_n;
  logic [9:0]       serve_x_n;
  logic             load_n;
  logic             sync1, sync2, sync3;
  logic             start_pulse;

  assign serve_y     = 9'd32;
  assign start_pulse = sync2 & ~sync3;

  // Two-digit BCD increment, holding at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      bcd_inc = v;
    else if (v[3:0] == 4'd9)
      bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else
      bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    hit_cnt_n   = hit_cnt;
    score_n     = score;
    lives_n     = lives;
    speed_n     = ball_speed;
    serve_x_n   = serve_x;
    load_n      = 1'b0;
    case (state)
      S_IDLE, S_OVER: begin
        if (start_pulse) begin
          state_n   = S_SERVE;
          score_n   = 8'h00;
          lives_n   = 3'(LIVES);
          speed_n   = 2'd0;
          hit_cnt_n = '0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (frame_cnt == '0) state_n = S_PLAY;
          else                 frame_cnt_n = frame_cnt - 1'b1;
        end
      end
      S_PLAY: begin
        // miss has priority: a simultaneous hit does not score
        if (miss) begin
          state_n     = S_MISS;
          lives_n     = (lives != 3'd0) ? lives - 3'd1 : 3'd0;
          speed_n     = 2'd0;
          hit_cnt_n   = '0;
          frame_cnt_n = FCW'(MISS_FRAMES - 1);
        end else if (hit) begin
          score_n   = bcd_inc(score);
          hit_cnt_n = hit_cnt + 1'b1;
          // counter is a power of two, so all-ones means it wraps on this hit
          if (hit_cnt == '1 && ball_speed != 2'd3) speed_n = ball_speed + 2'd1;
        end
      end
      S_MISS: begin
        if (frame_tick) begin
          if (frame_cnt == '0) state_n = (lives == 3'd0) ? S_OVER : S_SERVE;
          else                 frame_cnt_n = frame_cnt - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Every entry into SERVE reloads the ball at a fresh pseudo-random X.
    if (state_n == S_SERVE && state != S_SERVE) begin
      frame_cnt_n = FCW'(SERVE_FRAMES - 1);
      load_n      = 1'b1;
      serve_x_n   = 10'd64 + {2'b00, lfsr};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      frame_cnt  <= '0;
      hit_cnt    <= '0;
      lfsr       <= 8'h01;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      ball_run   <= 1'b0;
      ball_load  <= 1'b0;
      serve_x    <= 10'd64;
      ball_speed <= 2'd0;
      score      <= 8'h00;
      lives      <= 3'd0;
      flash      <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      sync1      <= start_btn;
      sync2      <= sync1;
      sync3      <= sync2;
      // Galois right-shift LFSR, taps for x^8+x^6+x^5+x^4+1
      lfsr       <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
      state      <= state_n;
      frame_cnt  <= frame_cnt_n;
      hit_cnt    <= hit_cnt_n;
      score      <= score_n;
      lives      <= lives_n;
      ball_speed <= speed_n;
      serve_x    <= serve_x_n;
      ball_load  <= load_n;
      // Outputs decoded from next-state so they line up with the state register.
      ball_run   <= (state_n == S_PLAY);
      game_over  <= (state_n == S_OVER);
      flash      <= (state_n == S_MISS) && frame_cnt_n[3];
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: directed scenarios with hand-computed expectations.
// Latency: inputs driven and outputs sampled on the falling edge of clk.
// Backpressure: none; a watchdog bounds the run.
module tb_pong_game_ctrl;

  localparam int SERVE_FRAMES = 60;
  localparam int MISS_FRAMES  = 90;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       ball_run, ball_load, flash, game_over;
  logic [9:0] serve_x;
  logic [8:0] serve_y;
  logic [1:0] ball_speed;
  logic [7:0] score;
  logic [2:0] lives;

  int tests_run = 0;
  int tests_failed = 0;

  pong_game_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .hit        (hit),
    .miss       (miss),
    .ball_run   (ball_run),
    .ball_load  (ball_load),
    .serve_x    (serve_x),
    .serve_y    (serve_y),
    .ball_speed (ball_speed),
    .score      (score),
    .lives      (lives),
    .flash      (flash),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_hit(input int n);
    repeat (n) begin
      hit = 1'b1;
      @(negedge clk);
      hit = 1'b0;
    end
  endtask

  task automatic pulse_miss;
    miss = 1'b1;
    @(negedge clk);
    miss = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({ball_run, ball_load, flash, game_over} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", {ball_run, ball_load, flash, game_over});
    end
    tests_run++;
    if (serve_x !== 10'd64) begin tests_failed++; $display("FAIL reset_serve_x: got %0d expected 64", serve_x); end
    tests_run++;
    if (serve_y !== 9'd32) begin tests_failed++; $display("FAIL reset_serve_y: got %0d expected 32", serve_y); end
    tests_run++;
    if (score !== 8'h00) begin tests_failed++; $display("FAIL reset_score: got %h expected 00", score); end
    tests_run++;
    if (lives !== 3'd0) begin tests_failed++; $display("FAIL reset_lives: got %0d expected 0", lives); end
    tests_run++;
    if (ball_speed !== 2'd0) begin tests_failed++; $display("FAIL reset_speed: got %0d expected 0", ball_speed); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if ({ball_run, ball_load, game_over} !== 3'b000) begin
      tests_failed++;
      $display("FAIL idle_hold: got %b expected 000", {ball_run, ball_load, game_over});
    end
  endtask

  task automatic test_start;
    start_btn = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (ball_load !== (c == 3)) begin
        tests_failed++;
        $display("FAIL start_load_clk%0d: got %b expected %b", c, ball_load, (c == 3));
      end
      if (c == 3) begin
        tests_run++;
        if (lives !== 3'd3 || score !== 8'h00) begin
          tests_failed++;
          $display("FAIL start_values: got lives %0d score %h expected lives 3 score 00", lives, score);
        end
        tests_run++;
        if (serve_x < 10'd64 || serve_x > 10'd319) begin
          tests_failed++;
          $display("FAIL serve_x_range: got %0d expected 64..319", serve_x);
        end
      end
    end
    start_btn = 1'b0;
  endtask

  task automatic test_serve;
    for (int k = 1; k <= SERVE_FRAMES; k++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      tests_run++;
      if (ball_run !== (k == SERVE_FRAMES)) begin
        tests_failed++;
        $display("FAIL serve_tick%0d_ball_run: got %b expected %b", k, ball_run, (k == SERVE_FRAMES));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hits;
    pulse_hit(8);
    tests_run++;
    if (ball_speed !== 2'd1 || score !== 8'h08) begin
      tests_failed++;
      $display("FAIL hits8: got speed %0d score %h expected speed 1 score 08", ball_speed, score);
    end
    pulse_hit(9);
    tests_run++;
    if (score !== 8'h17) begin tests_failed++; $display("FAIL hits17_score: got %h expected 17", score); end
    tests_run++;
    if (ball_speed !== 2'd2) begin tests_failed++; $display("FAIL hits17_speed: got %0d expected 2", ball_speed); end
    pulse_hit(99);
    tests_run++;
    if (score !== 8'h99) begin tests_failed++; $display("FAIL hits_sat_score: got %h expected 99", score); end
    tests_run++;
    if (ball_speed !== 2'd3) begin tests_failed++; $display("FAIL hits_sat_speed: got %0d expected 3", ball_speed); end
  endtask

  task automatic test_hit_miss;
    int cnt;
    hit = 1'b1;
    miss = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    miss = 1'b0;
    tests_run++;
    if (score !== 8'h99 || lives !== 3'd2 || ball_speed !== 2'd0) begin
      tests_failed++;
      $display("FAIL hit_miss: got score %h lives %0d speed %0d expected 99 2 0", score, lives, ball_speed);
    end
    tests_run++;
    if (ball_run !== 1'b0 || flash !== 1'b1) begin
      tests_failed++;
      $display("FAIL miss_entry: got run %b flash %b expected 0 1", ball_run, flash);
    end
    for (int k = 1; k <= MISS_FRAMES; k++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      cnt = MISS_FRAMES - 1 - k;
      if (k < MISS_FRAMES) begin
        tests_run++;
        if (flash !== 1'((cnt >> 3) & 1) || ball_load !== 1'b0) begin
          tests_failed++;
          $display("FAIL miss_tick%0d: got flash %b load %b expected flash %0d load 0", k, flash, ball_load, (cnt >> 3) & 1);
        end
      end else begin
        tests_run++;
        if (ball_load !== 1'b1 || flash !== 1'b0 || lives !== 3'd2) begin
          tests_failed++;
          $display("FAIL miss_to_serve: got load %b flash %b lives %0d expected 1 0 2", ball_load, flash, lives);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (ball_load !== 1'b0) begin tests_failed++; $display("FAIL reserve_load_single: got %b expected 0", ball_load); end
  endtask

  task automatic test_game_over;
    do_ticks(SERVE_FRAMES);
    tests_run++;
    if (ball_run !== 1'b1) begin tests_failed++; $display("FAIL play2_run: got %b expected 1", ball_run); end
    pulse_miss();
    tests_run++;
    if (lives !== 3'd1) begin tests_failed++; $display("FAIL miss2_lives: got %0d expected 1", lives); end
    do_ticks(MISS_FRAMES);
    do_ticks(SERVE_FRAMES);
    pulse_miss();
    tests_run++;
    if (lives !== 3'd0) begin tests_failed++; $display("FAIL miss3_lives: got %0d expected 0", lives); end
    do_ticks(MISS_FRAMES);
    tests_run++;
    if (game_over !== 1'b1 || ball_run !== 1'b0 || ball_load !== 1'b0) begin
      tests_failed++;
      $display("FAIL game_over: got over %b run %b load %b expected 1 0 0", game_over, ball_run, ball_load);
    end
    pulse_hit(1);
    pulse_miss();
    repeat (2) @(negedge clk);
    tests_run++;
    if (score !== 8'h99 || lives !== 3'd0 || game_over !== 1'b1) begin
      tests_failed++;
      $display("FAIL over_ignore: got score %h lives %0d over %b expected 99 0 1", score, lives, game_over);
    end
    start_btn = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (ball_load !== 1'b1 || score !== 8'h00 || lives !== 3'd3 || game_over !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart: got load %b score %h lives %0d over %b expected 1 00 3 0", ball_load, score, lives, game_over);
    end
    start_btn = 1'b0;
  endtask

  task automatic test_reset_mid_game;
    do_ticks(SERVE_FRAMES);
    pulse_hit(5);
    tests_run++;
    if (score !== 8'h05 || ball_run !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset: got score %h run %b expected 05 1", score, ball_run);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({ball_run, ball_load, flash, game_over, ball_speed, score, lives, serve_x, serve_y} !==
        {4'b0000, 2'd0, 8'h00, 3'd0, 10'd64, 9'd32}) begin
      tests_failed++;
      $display("FAIL midgame_reset: got run %b load %b speed %0d score %h lives %0d sx %0d sy %0d",
               ball_run, ball_load, ball_speed, score, lives, serve_x, serve_y);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests_run++;
      if (ball_load !== 1'b0 || ball_run !== 1'b0 || lives !== 3'd0) begin
        tests_failed++;
        $display("FAIL post_reset_idle%0d: got load %b run %b lives %0d expected 0 0 0", c, ball_load, ball_run, lives);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_serve();
    test_hits();
    test_hit_miss();
    test_game_over();
    test_reset_mid_game();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
